// File: rtl/sd_card_cmd_engine.sv
// SD card command engine: sends a 48-bit command frame, collects R1/R3/R7/R1b responses.
// Define SD_CMD_CRC7_EN to compute the real CRC7; otherwise the CRC field is fixed at 7'h4A.
module sd_card_cmd_engine #(
   parameter int RSP_TIMEOUT  = 64,
   parameter int BUSY_TIMEOUT = 65535
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [5:0]  i_cmd_index,
   input  logic [31:0] i_cmd_arg,
   input  logic [1:0]  i_rsp_type,
   input  logic        i_miso,
   output logic        o_mosi,
   output logic        o_busy,
   output logic        o_done,
   output logic [1:0]  o_status,
   output logic [7:0]  o_r1,
   output logic [31:0] o_rsp_data,
   output logic [2:0]  o_dbg_state
);

   localparam int TMAX = (BUSY_TIMEOUT > RSP_TIMEOUT) ? BUSY_TIMEOUT : RSP_TIMEOUT;
   localparam int CW   = $clog2(((TMAX > 48) ? TMAX : 48) + 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      SEND     = 3'd2,
      WAIT_RSP = 3'd3,
      RECV     = 3'd4,
      BUSY     = 3'd5,
      DONE     = 3'd6
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [46:0]   sh;
   logic [39:0]   rx;
   logic          long_q;
   logic          busy_q;
   logic [39:0]   hdr;
   logic [6:0]    crc;
   logic [47:0]   frame_n;
   logic [39:0]   rx_n;
   logic [7:0]    r1_n;
   logic [CW-1:0] recv_last;

`ifdef SD_CMD_CRC7_EN
   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = 7'd0;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
      return c;
   endfunction
   assign crc = crc7(hdr);
`else
   assign crc = 7'h4A;
`endif

   assign hdr         = {2'b01, i_cmd_index, i_cmd_arg};
   assign frame_n     = {hdr, crc, 1'b1};
   assign rx_n        = {rx[38:0], i_miso};
   // R3/R7 carry the R1 byte in the top 8 of 40 bits; short responses in the low byte.
   assign r1_n        = long_q ? rx_n[39:32] : rx_n[7:0];
   assign recv_last   = long_q ? CW'(38) : CW'(6);
   assign o_dbg_state = state;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= IDLE;
         cnt        <= '0;
         sh         <= '0;
         rx         <= '0;
         long_q     <= 1'b0;
         busy_q     <= 1'b0;
         o_mosi     <= 1'b1;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_status   <= 2'd0;
         o_r1       <= 8'hFF;
         o_rsp_data <= 32'd0;
      end else begin
         o_done <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  state  <= LOAD;
                  o_busy <= 1'b1;
               end
            end
            LOAD: begin
               long_q     <= (i_rsp_type == 2'd1);
               busy_q     <= (i_rsp_type == 2'd2);
               o_mosi     <= frame_n[47];
               sh         <= frame_n[46:0];
               cnt        <= '0;
               o_r1       <= 8'hFF;
               o_rsp_data <= 32'd0;
               state      <= SEND;
            end
            SEND: begin
               if (cnt == CW'(47)) begin
                  o_mosi <= 1'b1;
                  cnt    <= '0;
                  state  <= WAIT_RSP;
               end else begin
                  o_mosi <= sh[46];
                  sh     <= {sh[45:0], 1'b0};
                  cnt    <= cnt + CW'(1);
               end
            end
            WAIT_RSP: begin
               if (!i_miso) begin
                  rx    <= '0;
                  cnt   <= '0;
                  state <= RECV;
               end else if (cnt == CW'(RSP_TIMEOUT - 1)) begin
                  o_status <= 2'd2;
                  o_done   <= 1'b1;
                  state    <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            RECV: begin
               rx <= rx_n;
               if (cnt == recv_last) begin
                  cnt        <= '0;
                  o_r1       <= r1_n;
                  o_rsp_data <= long_q ? rx_n[31:0] : 32'd0;
                  // r1[0] is the idle flag and never counts as an error.
                  if (|r1_n[6:1]) begin
                     o_status <= 2'd1;
                     o_done   <= 1'b1;
                     state    <= DONE;
                  end else if (busy_q) begin
                     state <= BUSY;
                  end else begin
                     o_status <= 2'd0;
                     o_done   <= 1'b1;
                     state    <= DONE;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            BUSY: begin
               if (i_miso) begin
                  o_status <= 2'd0;
                  o_done   <= 1'b1;
                  state    <= DONE;
               end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                  o_status <= 2'd3;
                  o_done   <= 1'b1;
                  state    <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               o_busy <= 1'b0;
               cnt    <= '0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
